// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: SPI mode-0 slave that fills a GRB frame buffer and hands
// frames to the ws2812 serialiser.
//   clk_i, reset_ni          system clock, async active-low reset
//   spi_sclk_i/cs_ni/mosi_i  host SPI inputs (async), spi_miso_o status out
//   data_request_i/address_i pixel read strobe and index from serialiser
//   red_o/green_o/blue_o     pixel read data, valid one cycle after request
//   start_o, busy_i          frame start strobe / serialiser busy
//   led_count_o              LEDs in frame (NUM_LEDS at a power of two reads 0)
// Optional: define SPI_PIX_BRIGHTNESS_EN for the 0x03 brightness command.
module spi_pixel_loader #(
  parameter  int NUM_LEDS          = 8,
  localparam int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS)
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         spi_sclk_i,
  input  logic                         spi_cs_ni,
  input  logic                         spi_mosi_i,
  output logic                         spi_miso_o,
  input  logic                         data_request_i,
  input  logic [LED_ADDRESS_WIDTH-1:0] address_i,
  output logic [7:0]                   red_o,
  output logic [7:0]                   green_o,
  output logic [7:0]                   blue_o,
  output logic                         start_o,
  input  logic                         busy_i,
  output logic [LED_ADDRESS_WIDTH-1:0] led_count_o
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, PIX_G, PIX_R, PIX_B, COUNT, BRIGHT, DISCARD
  } spi_state_t;

  spi_state_t state, state_next;

  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_rise, sclk_fall, cs_high, cs_fall;

  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic [7:0] rx_byte;
  logic       byte_done;

  logic [LED_ADDRESS_WIDTH-1:0] ptr, ptr_inc, addr_mod;
  logic [LED_ADDRESS_WIDTH-1:0] wr_addr, shadow, count_value;
  logic [7:0]                   g_q, r_q, status_q;
  logic [23:0]                  wr_data, rd_q;
  logic                         wr_en, pending, count_load;

  logic [23:0] mem [NUM_LEDS];

  // cs sync resets low so a chip select already active at reset release
  // does not look like a fresh falling edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
      cs_sync   <= {cs_sync[1:0], spi_cs_ni};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_high   = cs_sync[1];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign rx_byte   = {shift_q, mosi_sync[1]};
  assign byte_done = sclk_rise && !cs_high && (bit_cnt == 3'd7);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (cs_high) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift_q <= {shift_q[5:0], mosi_sync[1]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    spi_miso_o = 1'b0;
    if (state == CMD) spi_miso_o = status_q[7];
    if (cs_high) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD: begin
          if (byte_done) begin
            case (rx_byte)
              8'h01:   state_next = ADDR;
              8'h02:   state_next = COUNT;
`ifdef SPI_PIX_BRIGHTNESS_EN
              8'h03:   state_next = BRIGHT;
`endif
              default: state_next = DISCARD;
            endcase
          end
        end
        ADDR:    if (byte_done) state_next = PIX_G;
        PIX_G:   if (byte_done) state_next = PIX_R;
        PIX_R:   if (byte_done) state_next = PIX_B;
        PIX_B:   if (byte_done) state_next = PIX_G;
        COUNT:   if (byte_done) state_next = DISCARD;
        BRIGHT:  if (byte_done) state_next = DISCARD;
        DISCARD: state_next = DISCARD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_mod = LED_ADDRESS_WIDTH'(int'(rx_byte) % NUM_LEDS);
    ptr_inc  = (ptr == LED_ADDRESS_WIDTH'(NUM_LEDS - 1)) ? '0 : ptr + LED_ADDRESS_WIDTH'(1);
    if (int'(rx_byte) > NUM_LEDS) count_value = LED_ADDRESS_WIDTH'(NUM_LEDS);
    else                          count_value = LED_ADDRESS_WIDTH'(rx_byte);
    count_load = (state == COUNT) && byte_done && (rx_byte != 8'h00);
  end

  // A COUNT landing in the same cycle as a start re-arms pending, so the
  // newer value still reaches led_count_o.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr         <= '0;
      g_q         <= '0;
      r_q         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      start_o     <= 1'b0;
      led_count_o <= '0;
      status_q    <= '0;
    end else begin
      wr_en   <= 1'b0;
      start_o <= 1'b0;
      if (byte_done) begin
        case (state)
          ADDR:  ptr <= addr_mod;
          PIX_G: g_q <= rx_byte;
          PIX_R: r_q <= rx_byte;
          PIX_B: begin
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= {g_q, r_q, rx_byte};
            ptr     <= ptr_inc;
          end
          default: ;
        endcase
      end
      if (pending && !busy_i) begin
        start_o     <= 1'b1;
        pending     <= 1'b0;
        led_count_o <= shadow;
      end
      if (count_load) begin
        shadow  <= count_value;
        pending <= 1'b1;
      end
      if (cs_fall)                         status_q <= {6'b0, busy_i, pending};
      else if (state == CMD && sclk_fall) status_q <= {status_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)           rd_q <= '0;
    else if (data_request_i) rd_q <= mem[address_i];
  end

`ifdef SPI_PIX_BRIGHTNESS_EN
  logic [7:0] bright;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                          bright <= 8'hFF;
    else if (state == BRIGHT && byte_done) bright <= rx_byte;
  end

  function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] level);
    logic [15:0] prod;
    prod = 16'(raw) * (16'(level) + 16'd1);
    return 8'(prod >> 8);
  endfunction

  always_comb begin
    green_o = scale(rd_q[23:16], bright);
    red_o   = scale(rd_q[15:8], bright);
    blue_o  = scale(rd_q[7:0], bright);
  end
`else
  always_comb begin
    green_o = rd_q[23:16];
    red_o   = rd_q[15:8];
    blue_o  = rd_q[7:0];
  end
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
module tb_spi_pixel_loader;
  localparam int NUM  = 8;
  localparam int AW   = $clog2(NUM);
  localparam int HALF = 80;

  logic          clk = 1'b0;
  logic          reset_ni, sclk, cs_n, mosi, miso, data_request, start, busy;
  logic [AW-1:0] address, led_count;
  logic [7:0]    red, green, blue;

  spi_pixel_loader #(.NUM_LEDS(NUM)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .spi_sclk_i(sclk), .spi_cs_ni(cs_n),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .data_request_i(data_request),
    .address_i(address), .red_o(red), .green_o(green), .blue_o(blue),
    .start_o(start), .busy_i(busy), .led_count_o(led_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [23:0] model_mem [NUM];
  bit          known [NUM];
  logic [7:0]  txb [32];
  int  mptr, model_count = 0, model_b = 255, pulses = 0, wait_cyc = 0, prev_lc = 0;
  bit  model_pending = 0, in_xfer = 0, exp_known = 1, prev_start = 0;
  int  exp_raw = 0;
  logic          req_q = 1'b0;
  logic [AW-1:0] addr_q = '0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int scl(input int raw, input int b);
    return (raw * (b + 1)) / 256;
  endfunction

  // Byte-level reference: effect of the k-th completed byte of a transaction.
  task automatic model_byte(input int k);
    case (txb[0])
      8'h01: begin
        if (k == 1) mptr = int'(txb[1]) % NUM;
        else if (k >= 4 && (k - 2) % 3 == 2) begin
          model_mem[mptr] = {txb[k-2], txb[k-1], txb[k]};
          known[mptr] = 1;
          mptr = (mptr + 1) % NUM;
        end
      end
      8'h02: if (k == 1 && txb[1] != 0) begin
        model_count = ((int'(txb[1]) > NUM) ? NUM : int'(txb[1])) % (1 << AW);
        model_pending = 1;
      end
`ifdef SPI_PIX_BRIGHTNESS_EN
      8'h03: if (k == 1) model_b = int'(txb[1]);
`endif
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    req_q  <= reset_ni && data_request;
    addr_q <= address;
  end

  always @(negedge clk) begin
    if (!reset_ni) begin
      chk("reset_rgb", {green, red, blue}, 0);
      chk("reset_start", start, 0);
      chk("reset_count", led_count, 0);
      chk("reset_miso", miso, 0);
      exp_raw = 0; exp_known = 1; model_pending = 0; model_count = 0;
      model_b = 255; prev_lc = 0; prev_start = 0; wait_cyc = 0;
    end else begin
      if (req_q) begin
        exp_known = known[addr_q];
        exp_raw   = int'(model_mem[addr_q]);
      end
      if (exp_known && !in_xfer) begin
        chk("green", green, scl((exp_raw >> 16) & 255, model_b));
        chk("red",   red,   scl((exp_raw >> 8) & 255, model_b));
        chk("blue",  blue,  scl(exp_raw & 255, model_b));
      end
      if (start) begin
        pulses++;
        chk("start_expected", model_pending, 1);
        chk("led_count_at_start", led_count, model_count);
        model_pending = 0;
      end
      if (start && prev_start) chk("start_width", 2, 1);
      if (!start && led_count != prev_lc) chk("led_count_hold", led_count, prev_lc);
      if (model_pending && !busy) wait_cyc++; else wait_cyc = 0;
      if (wait_cyc > 12) begin
        chk("start_timeout", 0, 1);
        model_pending = 0;
        wait_cyc = 0;
      end
      prev_start = start;
      prev_lc = int'(led_count);
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i]; #(HALF); sclk = 1; #(HALF); sclk = 0;
    end
  endtask

  // exp_status < 0 skips the status check on the first byte.
  task automatic spi_xfer(input int n, input int exp_status);
    in_xfer = 1;
    cs_n = 0; #(HALF);
    for (int k = 0; k < n; k++) begin
      logic [7:0] rx;
      for (int i = 7; i >= 0; i--) begin
        mosi = txb[k][i]; #(HALF);
        rx[i] = miso;
        sclk = 1;
        if (i == 0) model_byte(k);
        #(HALF); sclk = 0;
      end
      if (k == 0 && exp_status >= 0) chk("miso_status", rx, exp_status);
      else if (k > 0)                chk("miso_idle", rx, 0);
    end
    #(HALF); cs_n = 1;
    repeat (10) @(posedge clk);
    #1 in_xfer = 0;
  endtask

  task automatic rd(input int a);
    data_request = 1; address = AW'(a);
    @(posedge clk); #1 data_request = 0;
  endtask

  task automatic rd_chk(input int a, input int expv, input string nm);
    rd(a);
    @(negedge clk);
    chk(nm, {green, red, blue}, expv);
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < NUM; a++) begin
      rd(a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fill1, pb, npix, nb, bright_exp;

  initial begin
    reset_ni = 0; cs_n = 1; sclk = 0; mosi = 0; busy = 0; data_request = 0; address = '0;
    for (int i = 0; i < NUM; i++) known[i] = 0;
    idle(5);
    reset_ni = 1;
    idle(3);

    // Single pixel write then readback.
    txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h11; txb[3] = 8'h22; txb[4] = 8'h33;
    spi_xfer(5, 0);
    rd_chk(2, 24'h112233, "write_read_addr2");

    // Fill buffer, then wrap from 7 with a trailing partial pixel.
    txb[0] = 8'h01; txb[1] = 8'h00;
    for (int i = 2; i < 26; i++) txb[i] = 8'($urandom_range(0, 255));
    fill1 = {txb[5], txb[6], txb[7]};
    spi_xfer(26, -1);
    read_all();
    txb[0] = 8'h01; txb[1] = 8'h07;
    txb[2] = 8'hA1; txb[3] = 8'hA2; txb[4] = 8'hA3;
    txb[5] = 8'hB1; txb[6] = 8'hB2; txb[7] = 8'hB3; txb[8] = 8'hC1; txb[9] = 8'hC2;
    spi_xfer(10, -1);
    rd_chk(7, 24'hA1A2A3, "wrap_addr7");
    rd_chk(0, 24'hB1B2B3, "wrap_addr0");
    rd_chk(1, fill1, "partial_untouched");

    // Unknown command must not write.
    txb[0] = 8'h7E; txb[1] = 8'h00;
    for (int i = 2; i < 8; i++) txb[i] = 8'(8'h55 + i);
    spi_xfer(8, -1);
    rd_chk(0, 24'hB1B2B3, "unknown_cmd_nowrite");
    read_all();

    // Show handshake, status and clamp.
    busy = 1;
    txb[0] = 8'h02; txb[1] = 8'h05;
    pb = pulses;
    spi_xfer(2, 2);
    idle(20);
    chk("no_start_while_busy", pulses - pb, 0);
    chk("count_held_while_busy", led_count, 0);
    txb[0] = 8'h7E;
    spi_xfer(1, 3);
    busy = 0;
    idle(15);
    chk("single_start", pulses - pb, 1);
    chk("count_5", led_count, 5);
    txb[0] = 8'h02; txb[1] = 8'h20;
    pb = pulses;
    spi_xfer(2, 0);
    idle(15);
    chk("clamp_start", pulses - pb, 1);
    chk("count_clamped", led_count, 0);
    busy = 1;
    pb = pulses;
    txb[0] = 8'h02; txb[1] = 8'h03; spi_xfer(2, 2);
    txb[0] = 8'h02; txb[1] = 8'h06; spi_xfer(2, 3);
    busy = 0;
    idle(15);
    chk("merged_start", pulses - pb, 1);
    chk("count_6", led_count, 6);
    pb = pulses;
    txb[0] = 8'h02; txb[1] = 8'h00; spi_xfer(2, 0);
    idle(15);
    chk("count_zero_ignored", pulses - pb, 0);
    txb[0] = 8'h7E; spi_xfer(1, 0);
    busy = 1;
    txb[0] = 8'h7E; spi_xfer(1, 2);
    busy = 0;

    // Brightness (command discarded in the default build).
    txb[0] = 8'h01; txb[1] = 8'h05; txb[2] = 8'hFF; txb[3] = 8'hFF; txb[4] = 8'hFF;
    spi_xfer(5, 0);
    txb[0] = 8'h03; txb[1] = 8'h7F;
    spi_xfer(2, 0);
`ifdef SPI_PIX_BRIGHTNESS_EN
    bright_exp = 24'h7F7F7F;
`else
    bright_exp = 24'hFFFFFF;
`endif
    rd_chk(5, bright_exp, "brightness");
    txb[0] = 8'h03; txb[1] = 8'hFF;
    spi_xfer(2, 0);

    // Randomized transactions.
    for (int it = 0; it < 18; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          npix = $urandom_range(1, 4);
          nb = 2 + 3 * npix + $urandom_range(0, 2);
          txb[0] = 8'h01; txb[1] = 8'($urandom_range(0, 255));
          for (int i = 2; i < nb; i++) txb[i] = 8'($urandom_range(0, 255));
          spi_xfer(nb, -1);
        end
        1: begin
          nb = $urandom_range(1, 7);
          txb[0] = 8'($urandom_range(4, 255));
          for (int i = 1; i < nb; i++) txb[i] = 8'($urandom_range(0, 255));
          spi_xfer(nb, -1);
        end
        default: begin
          busy = 1'($urandom_range(0, 1));
          txb[0] = 8'h02; txb[1] = 8'($urandom_range(0, 255));
          spi_xfer(2, -1);
          busy = 0;
          idle(15);
        end
      endcase
      read_all();
    end

    // Reset in the middle of the red byte.
    idle(2);
    in_xfer = 1;
    cs_n = 0; #(HALF);
    txb[0] = 8'h01; txb[1] = 8'h03;
    spi_bits(8'h01, 8); spi_bits(8'h03, 8); spi_bits(8'hAA, 8); spi_bits(8'h55, 4);
    #33 reset_ni = 0;
    repeat (3) @(negedge clk);
    chk("midreset_green", green, 0);
    chk("midreset_count", led_count, 0);
    chk("midreset_start", start, 0);
    sclk = 0; mosi = 0; cs_n = 1;
    idle(3);
    reset_ni = 1;
    idle(4);
    in_xfer = 0;
    txb[0] = 8'h01; txb[1] = 8'h04; txb[2] = 8'h12; txb[3] = 8'h34; txb[4] = 8'h56;
    spi_xfer(5, 0);
    rd_chk(4, 24'h123456, "after_reset_parse");
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_pixel_loader.md
Name: spi_pixel_loader

Overview:
SPI-slave front end for the ws2812 serialiser. It receives pixel data and commands from an external host over SPI (mode 0) and stores GRB pixels in an on-chip dual-port frame buffer. It serves the serialiser's data requests and issues the frame start strobe plus the LED count. It sits directly upstream of ws2812, wired to its start_i, busy_o, data_request_o, address_o, red_i/green_i/blue_i and led_count_i.

Parameters:
NUM_LEDS, 8, pixels in buffer; 2..256
LED_ADDRESS_WIDTH, $clog2(NUM_LEDS), width of address/count ports (derived, localparam)

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
spi_sclk_i  in  1  SPI clock, async to clk_i, ≤ clk_i/8
spi_cs_ni  in  1  SPI chip select, active low, async
spi_mosi_i  in  1  SPI data in, async
spi_miso_o  out  1  SPI status out
data_request_i  in  1  from serialiser; read strobe
address_i  in  LED_ADDRESS_WIDTH  pixel index to read
red_o  out  8  pixel red
green_o  out  8  pixel green
blue_o  out  8  pixel blue
start_o  out  1  one-cycle frame start strobe to serialiser
busy_i  in  1  serialiser busy
led_count_o  out  LED_ADDRESS_WIDTH  LEDs in frame

Behaviour:
- Reset (reset_ni low, async): all outputs 0, show_pending 0, SPI FSM to IDLE, byte counter 0. Frame buffer contents are not reset.
- Sync: sclk, cs_n, mosi each pass through a 2-FF synchroniser. SCLK edges are detected from sync stage 2 vs a stage 3 register. MOSI is sampled on the detected rising edge, MSB first. A byte completes on the 8th rising edge.
- cs_n high (synchronised): FSM to IDLE, bit count 0, any partial byte or pixel discarded, spi_miso_o = 0.
- SPI FSM states: IDLE, CMD, ADDR, PIX_G, PIX_R, PIX_B, COUNT, BRIGHT, DISCARD.
  - IDLE→CMD on cs_n falling.
  - CMD byte 0x01 → ADDR; 0x02 → COUNT; 0x03 → BRIGHT (feature only, else DISCARD); other values → DISCARD.
  - ADDR: write pointer = byte mod NUM_LEDS → PIX_G.
  - PIX_G/PIX_R/PIX_B latch one byte each. On the PIX_B byte, the 24-bit {G,R,B} is written to buffer[ptr] in the following clk cycle. The pointer then increments, wrapping NUM_LEDS-1→0, and the FSM returns to PIX_G.
  - COUNT: N = byte; N=0 ignored; N>NUM_LEDS clamped to NUM_LEDS. led_count_o <= N truncated to LED_ADDRESS_WIDTH (NUM_LEDS at a power of two encodes as 0). Sets show_pending → DISCARD.
  - DISCARD: ignore bytes until cs_n high.
- MISO: during the CMD byte, shifts out status {6'b0, busy_i, show_pending} sampled at cs_n fall, MSB first. It updates on detected SCLK falling edges, with bit 7 driven from cs_n fall. Otherwise 0.
- Start handshake: when show_pending=1 and busy_i=0, pulse start_o high for exactly one cycle and clear show_pending. A COUNT arriving while pending overwrites led_count_o and keeps a single pending request. led_count_o is not changed while busy_i=1; a new COUNT is held in a shadow register and applied at start_o.
- Read port: when data_request_i=1, red_o/green_o/blue_o <= buffer[address_i] on the next edge. Outputs are valid the cycle after the request and hold otherwise.
- Read and write to the same address in the same cycle: the read returns old data (read-before-write).
- Buffer: NUM_LEDS x 24 simple dual-port, inferable as block RAM.

Optional Feature:
Macro SPI_PIX_BRIGHTNESS_EN.
- Enabled: command 0x03 plus one byte sets an 8-bit brightness register b (reset 0xFF). Each colour output = (raw × (b+1)) >> 8, applied combinationally after the read register, so latency stays 1 cycle. With b=0xFF, outputs equal raw values.
- Disabled: 0x03 is treated as unknown (DISCARD); outputs are raw.

Test Plan:
- Reset mid-transfer: assert reset_ni during PIX_R → outputs 0, start_o 0, next transaction parses from CMD.
- Write and read: cmd 0x01, addr 0x02, bytes 0x11,0x22,0x33 → data_request_i with address_i=2 gives green_o=0x11, red_o=0x22, blue_o=0x33 one cycle later.
- Wrap and partial pixel (NUM_LEDS=8): addr 7, two full pixels plus two extra bytes, then cs_n high → buffer[7] and buffer[0] written, buffer[1] unchanged.
- Show handshake: cmd 0x02 count 5 with busy_i=1 → no start_o. busy_i falls → single 1-cycle start_o, led_count_o=5. Count 0x20 → clamped to 8 (encoded 0).
- Status/MISO: show pending with busy_i=1, then cmd byte → MISO bits read 0x03. Unknown cmd 0x7E followed by pixel bytes → no buffer writes.
- Feature on: brightness 0x7F, pixel raw 0xFF → output 0x7F; feature off: same sequence → output 0xFF.
